bbox_detect: RTL and testbench

- Upstream stage of the gimbal tracking path: consumes the binarized camera pixel stream and measures the bounding box of target pixels in each frame.
- Once per frame, publishes x_min/x_max/y_min/y_max to the direction-select stage, which drives the stepper-rate generator.
- Drives an active-high `lost` flag sized to feed the selector's active-low enable input directly. While lost=1, the selector holds still.

---
 rtl/bbox_detect.sv | 157 +++++++++++++++
 tb/tb_bbox_detect.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bbox_detect.sv
// bbox_detect
//   Measures the bounding box of target pixels in a binarized pixel stream and
//   publishes it once per frame. The box is committed on the rising edge of
//   vsync. A frame with fewer than MIN_PIX hits keeps the previous box and
//   raises lost.
//
// Ports
//   clk        system/pixel clock
//   rst        asynchronous active-high reset
//   vsync      frame sync; rising edge ends the frame being accumulated
//   de         data enable, high during the active pixels of a line
//   pix_hit    binarized pixel (1 = target), qualified by de
//   x_min/x_max  leftmost/rightmost target column of the last good frame
//   y_min/y_max  topmost/bottommost target line of the last good frame
//   lost       1 = last evaluated frame had too few hits; box is held
//   frame_done one-cycle pulse each time a frame is evaluated
module bbox_detect #(
   parameter int H_ACT   = 1280,
   parameter int V_ACT   = 800,
   parameter int MIN_PIX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        de,
   input  logic        pix_hit,
   output logic [10:0] x_min,
   output logic [10:0] x_max,
   output logic [9:0]  y_min,
   output logic [9:0]  y_max,
   output logic        lost,
   output logic        frame_done
);

   localparam logic [10:0] X_LIM  = 11'(H_ACT);
   localparam logic [10:0] X_LAST = 11'(H_ACT - 1);
   localparam logic [10:0] X_MID  = 11'(H_ACT / 2);
   localparam logic [9:0]  Y_LIM  = 10'(V_ACT);
   localparam logic [9:0]  Y_LAST = 10'(V_ACT - 1);
   localparam logic [9:0]  Y_MID  = 10'(V_ACT / 2);
   localparam logic [20:0] HIT_MIN = 21'(MIN_PIX);

   logic        vs_d_q, de_d_q;
   logic [10:0] x_cnt_q, x_cnt_d;
   logic [9:0]  y_cnt_q, y_cnt_d;
   logic [10:0] wx_min_q, wx_min_d, wx_max_q, wx_max_d;
   logic [9:0]  wy_min_q, wy_min_d, wy_max_q, wy_max_d;
   logic [20:0] hit_cnt_q, hit_cnt_d;
   logic [10:0] x_min_q, x_min_d, x_max_q, x_max_d;
   logic [9:0]  y_min_q, y_min_d, y_max_q, y_max_d;
   logic        lost_q, lost_d;
   logic        frame_done_q, frame_done_d;

   logic vs_rise, de_fall, hit_ok;

   always_comb begin
      vs_rise = vsync & ~vs_d_q;
      de_fall = ~de & de_d_q;
      // A pixel on the commit cycle belongs to neither frame.
      hit_ok  = de & pix_hit & ~vs_rise & (x_cnt_q < X_LIM) & (y_cnt_q < Y_LIM);

      x_cnt_d      = x_cnt_q;
      y_cnt_d      = y_cnt_q;
      wx_min_d     = wx_min_q;
      wx_max_d     = wx_max_q;
      wy_min_d     = wy_min_q;
      wy_max_d     = wy_max_q;
      hit_cnt_d    = hit_cnt_q;
      x_min_d      = x_min_q;
      x_max_d      = x_max_q;
      y_min_d      = y_min_q;
      y_max_d      = y_max_q;
      lost_d       = lost_q;
      frame_done_d = 1'b0;

      if (vs_rise || de_fall) begin
         x_cnt_d = '0;
      end else if (de && (x_cnt_q != '1)) begin
         x_cnt_d = x_cnt_q + 11'd1;
      end

      // vs_rise clear takes priority over a coincident line end.
      if (vs_rise) begin
         y_cnt_d = '0;
      end else if (de_fall && (y_cnt_q != '1)) begin
         y_cnt_d = y_cnt_q + 10'd1;
      end

      if (vs_rise) begin
         frame_done_d = 1'b1;
         if (hit_cnt_q >= HIT_MIN) begin
            x_min_d = wx_min_q;
            x_max_d = wx_max_q;
            y_min_d = wy_min_q;
            y_max_d = wy_max_q;
            lost_d  = 1'b0;
         end else begin
            lost_d  = 1'b1;
         end
         wx_min_d  = X_LAST;
         wx_max_d  = '0;
         wy_min_d  = Y_LAST;
         wy_max_d  = '0;
         hit_cnt_d = '0;
      end else if (hit_ok) begin
         if (x_cnt_q < wx_min_q) wx_min_d = x_cnt_q;
         if (x_cnt_q > wx_max_q) wx_max_d = x_cnt_q;
         if (y_cnt_q < wy_min_q) wy_min_d = y_cnt_q;
         if (y_cnt_q > wy_max_q) wy_max_d = y_cnt_q;
         if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 21'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_d_q       <= 1'b0;
         de_d_q       <= 1'b0;
         x_cnt_q      <= '0;
         y_cnt_q      <= '0;
         wx_min_q     <= X_LAST;
         wx_max_q     <= '0;
         wy_min_q     <= Y_LAST;
         wy_max_q     <= '0;
         hit_cnt_q    <= '0;
         x_min_q      <= X_MID;
         x_max_q      <= X_MID;
         y_min_q      <= Y_MID;
         y_max_q      <= Y_MID;
         lost_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         vs_d_q       <= vsync;
         de_d_q       <= de;
         x_cnt_q      <= x_cnt_d;
         y_cnt_q      <= y_cnt_d;
         wx_min_q     <= wx_min_d;
         wx_max_q     <= wx_max_d;
         wy_min_q     <= wy_min_d;
         wy_max_q     <= wy_max_d;
         hit_cnt_q    <= hit_cnt_d;
         x_min_q      <= x_min_d;
         x_max_q      <= x_max_d;
         y_min_q      <= y_min_d;
         y_max_q      <= y_max_d;
         lost_q       <= lost_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign x_min      = x_min_q;
   assign x_max      = x_max_q;
   assign y_min      = y_min_q;
   assign y_max      = y_max_q;
   assign lost       = lost_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bbox_detect.sv
// tb_bbox_detect
//   Directed bench for bbox_detect. Each frame is described by up to three
//   hit rectangles plus the box/lost values expected after its commit.
module tb_bbox_detect;

   logic        clk = 1'b0;
   logic        rst, vsync, de, pix_hit;
   logic [10:0] x_min, x_max;
   logic [9:0]  y_min, y_max;
   logic        lost, frame_done;

   bbox_detect #(.H_ACT(1280), .V_ACT(800), .MIN_PIX(16)) dut (
      .clk(clk), .rst(rst), .vsync(vsync), .de(de), .pix_hit(pix_hit),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .lost(lost), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x0; int x1; int y0; int y1;
   } rect_t;

   typedef struct {
      string name;
      rect_t r0; rect_t r1; rect_t r2;
      int    ex_min; int ex_max; int ey_min; int ey_max;
      int    e_lost;
   } vec_t;

   // Extra de cycles after the last hit on a hit line.
   localparam int TAIL = 14;

   int    n_cmp = 0;
   int    n_bad = 0;
   rect_t NONE;
   vec_t  tbl [6];
   vec_t  v;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic rect_t mkr(input int x0, input int x1, input int y0, input int y1);
      rect_t r;
      r.x0 = x0; r.x1 = x1; r.y0 = y0; r.y1 = y1;
      return r;
   endfunction

   function automatic vec_t mkv(input string n, input rect_t a, input rect_t b, input rect_t c,
                                input int xmn, input int xmx, input int ymn, input int ymx,
                                input int ls);
      vec_t f;
      f.name = n; f.r0 = a; f.r1 = b; f.r2 = c;
      f.ex_min = xmn; f.ex_max = xmx; f.ey_min = ymn; f.ey_max = ymx; f.e_lost = ls;
      return f;
   endfunction

   function automatic rect_t rsel(input vec_t f, input int i);
      case (i)
         0:       return f.r0;
         1:       return f.r1;
         default: return f.r2;
      endcase
   endfunction

   function automatic bit hit_at(input vec_t f, input int x, input int y);
      for (int i = 0; i < 3; i++) begin
         rect_t r = rsel(f, i);
         if (x >= r.x0 && x <= r.x1 && y >= r.y0 && y <= r.y1) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int line_len(input vec_t f, input int y);
      int len = 1;
      for (int i = 0; i < 3; i++) begin
         rect_t r = rsel(f, i);
         if (r.x0 <= r.x1 && y >= r.y0 && y <= r.y1 && r.x1 + 1 + TAIL > len)
            len = r.x1 + 1 + TAIL;
      end
      return len;
   endfunction

   function automatic int last_line(input vec_t f);
      int last = -1;
      for (int i = 0; i < 3; i++) begin
         rect_t r = rsel(f, i);
         if (r.x0 <= r.x1 && r.y0 <= r.y1 && r.y1 > last) last = r.y1;
      end
      return last;
   endfunction

   task automatic drive_frame(input vec_t f);
      for (int y = 0; y <= last_line(f); y++) begin
         int len = line_len(f, y);
         for (int x = 0; x < len; x++) begin
            de      = 1'b1;
            pix_hit = hit_at(f, x, y);
            tick();
         end
         de      = 1'b0;
         pix_hit = 1'b0;
         tick();
      end
   endtask

   // Raise vsync (optionally with a pixel on the same cycle), check the
   // committed outputs one clock later, then count any further pulses.
   task automatic commit_check(input vec_t f, input int hold, input bit de_v, input bit pix_v);
      int extra = 0;
      vsync   = 1'b1;
      de      = de_v;
      pix_hit = pix_v;
      tick();
      de      = 1'b0;
      pix_hit = 1'b0;
      chk({f.name, ".frame_done"}, int'(frame_done), 1);
      chk({f.name, ".x_min"}, int'(x_min), f.ex_min);
      chk({f.name, ".x_max"}, int'(x_max), f.ex_max);
      chk({f.name, ".y_min"}, int'(y_min), f.ey_min);
      chk({f.name, ".y_max"}, int'(y_max), f.ey_max);
      chk({f.name, ".lost"}, int'(lost), f.e_lost);
      repeat (hold) begin
         tick();
         extra += int'(frame_done);
      end
      vsync = 1'b0;
      repeat (3) begin
         tick();
         extra += int'(frame_done);
      end
      chk({f.name, ".extra_done"}, extra, 0);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, ".x_min"}, int'(x_min), 640);
      chk({nm, ".x_max"}, int'(x_max), 640);
      chk({nm, ".y_min"}, int'(y_min), 400);
      chk({nm, ".y_max"}, int'(y_max), 400);
      chk({nm, ".lost"}, int'(lost), 1);
      chk({nm, ".frame_done"}, int'(frame_done), 0);
   endtask

   initial begin
      NONE = mkr(1, 0, 1, 0);

      tbl[0] = mkv("empty", NONE, NONE, NONE, 640, 640, 400, 400, 1);
      tbl[1] = mkv("block20", mkr(100, 119, 600, 619), NONE, NONE, 100, 119, 600, 619, 0);
      tbl[2] = mkv("hits15", mkr(0, 14, 0, 0), NONE, NONE, 100, 119, 600, 619, 1);
      tbl[3] = mkv("corners", mkr(5, 5, 10, 10), mkr(1270, 1270, 790, 790),
                   mkr(600, 613, 400, 400), 5, 1270, 10, 790, 0);
      tbl[4] = mkv("overlong", mkr(300, 300, 50, 69), mkr(1285, 1285, 50, 50), NONE,
                   300, 300, 50, 69, 0);
      tbl[5] = mkv("hits16", mkr(20, 35, 3, 3), NONE, NONE, 20, 35, 3, 3, 0);

      rst = 1'b1; vsync = 1'b0; de = 1'b0; pix_hit = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk_reset_state("reset");

      for (int i = 0; i < 6; i++) begin
         drive_frame(tbl[i]);
         commit_check(tbl[i], 4, 1'b0, 1'b0);
      end

      // 15 hits plus a pixel on the vs_rise cycle: must stay lost, and the
      // dropped pixel must not leak into the next 15-hit frame either.
      v = mkv("vs_drop_a", mkr(0, 14, 0, 0), NONE, NONE, 20, 35, 3, 3, 1);
      drive_frame(v);
      commit_check(v, 4, 1'b1, 1'b1);
      v = mkv("vs_drop_b", mkr(0, 14, 0, 0), NONE, NONE, 20, 35, 3, 3, 1);
      drive_frame(v);
      commit_check(v, 4, 1'b0, 1'b0);

      // Long vsync: exactly one evaluation.
      v = mkv("vsync_long", NONE, NONE, NONE, 20, 35, 3, 3, 1);
      commit_check(v, 50, 1'b0, 1'b0);

      // Good frame, then reset in the middle of a 100-hit frame.
      v = mkv("pre_reset", mkr(200, 219, 5, 5), NONE, NONE, 200, 219, 5, 5, 0);
      drive_frame(v);
      commit_check(v, 4, 1'b0, 1'b0);
      v = mkv("partial", mkr(0, 99, 0, 0), NONE, NONE, 0, 0, 0, 0, 0);
      drive_frame(v);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk_reset_state("mid_reset");
      v = mkv("post_reset", NONE, NONE, NONE, 640, 640, 400, 400, 1);
      commit_check(v, 4, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
